// File: rtl/param_sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the param_sync_fifo buffer.
package param_sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_AF_THRESH  = 56;
  localparam int DEF_AE_THRESH  = 8;

  function automatic int calc_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Thresholds must satisfy 0 <= ae < af <= depth.
  function automatic bit thresh_ok(input int ae, input int af, input int depth);
    return (ae >= 0) && (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer bus of param_sync_fifo; slave is the FIFO side, master the user side.
// Handshake: a write is taken at the edge where wr_en is high and the FIFO is not full (or is full
// with rd_en also high); a read is taken where rd_en is high and the FIFO is not empty.
interface param_sync_fifo_if
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] buf_in;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] buf_out;
  logic                  rd_valid;
  logic [ADDR_WIDTH:0]   fifo_counter;
  logic                  buf_empty;
  logic                  buf_full;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  wr_en, rd_en, buf_in, clr_err,
    output buf_out, rd_valid, fifo_counter, buf_empty, buf_full,
           almost_full, almost_empty, overflow, underflow
  );

  modport master (
    output wr_en, rd_en, buf_in, clr_err,
    input  buf_out, rd_valid, fifo_counter, buf_empty, buf_full,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo_mem.sv
// Storage array of param_sync_fifo: synchronous write, registered read (async read when
// PARAM_SYNC_FIFO_FWFT_EN is defined).
module param_sync_fifo_mem
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
`ifndef PARAM_SYNC_FIFO_FWFT_EN
  input  logic                  rst,
  input  logic                  i_rd_en,
`endif
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);
  localparam int DEPTH = calc_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  assign o_rd_data = r_mem[i_rd_addr];
`else
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Reading before the same-edge write lands means a full-FIFO pass returns the old word.
  always_ff @(posedge clk) begin
    if (rst)          r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
`endif
endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with almost flags and sticky error flags.
// PARAM_SYNC_FIFO_FWFT_EN selects first-word-fall-through reads; default is one-cycle read latency.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input logic               clk,
  input logic               rst,
  param_sync_fifo_if.slave  bus
);
  localparam int DEPTH = calc_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   C_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_AF     = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   C_AE     = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   C_CNT_1  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_PTR_1  = ADDR_WIDTH'(1);

  if (!thresh_ok(AE_THRESH, AF_THRESH, DEPTH)) begin : g_bad_thresh
    $error("param_sync_fifo: illegal AE_THRESH/AF_THRESH for DEPTH");
  end

  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_next;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_rd_ok = bus.rd_en & ~w_empty;
  assign w_wr_ok = bus.wr_en & (~w_full | bus.rd_en);

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_next = r_count + C_CNT_1;
      2'b01:   w_count_next = r_count - C_CNT_1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + C_PTR_1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + C_PTR_1;
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en & ~w_wr_ok) r_overflow <= 1'b1;
      else if (bus.clr_err)     r_overflow <= 1'b0;
      if (bus.rd_en & ~w_rd_ok) r_underflow <= 1'b1;
      else if (bus.clr_err)     r_underflow <= 1'b0;
    end
  end

  param_sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo_mem (
    .clk       (clk),
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    .rst       (rst),
    .i_rd_en   (w_rd_ok & ~rst),
`endif
    .i_wr_en   (w_wr_ok & ~rst),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.buf_in),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  assign bus.rd_valid = ~w_empty;
`else
  logic r_rd_valid;

  always_ff @(posedge clk) begin
    if (rst) r_rd_valid <= 1'b0;
    else     r_rd_valid <= w_rd_ok;
  end

  assign bus.rd_valid = r_rd_valid;
`endif

  assign bus.buf_out      = w_rd_data;
  assign bus.fifo_counter = r_count;
  assign bus.buf_empty    = w_empty;
  assign bus.buf_full     = w_full;
  assign bus.almost_full  = (r_count >= C_AF);
  assign bus.almost_empty = (r_count <= C_AE);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: reference occupancy/error model plus a data queue.
module tb_param_sync_fifo;
  import param_sync_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int AF    = 56;
  localparam int AE    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  param_sync_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];
  int            m_count  = 0;
  bit            m_ovf    = 1'b0;
  bit            m_udf    = 1'b0;
  logic [DW-1:0] m_last   = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check_eq("fifo_counter", 32'(bus.fifo_counter), 32'(m_count));
    check_eq("buf_empty",    32'(bus.buf_empty),    32'(m_count == 0));
    check_eq("buf_full",     32'(bus.buf_full),     32'(m_count == DEPTH));
    check_eq("almost_full",  32'(bus.almost_full),  32'(m_count >= AF));
    check_eq("almost_empty", 32'(bus.almost_empty), 32'(m_count <= AE));
    check_eq("overflow",     32'(bus.overflow),     32'(m_ovf));
    check_eq("underflow",    32'(bus.underflow),    32'(m_udf));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    check_eq("fwft_rd_valid", 32'(bus.rd_valid), 32'(m_count != 0));
    if (m_count != 0) check_eq("fwft_head", 32'(bus.buf_out), 32'(exp_q[0]));
`endif
  endtask

  // One clock of stimulus; the model decides acceptance before the edge.
  task automatic step(input bit wr, input bit rd, input bit clr, input logic [DW-1:0] data);
    bit            rd_ok;
    bit            wr_ok;
    logic [DW-1:0] popped;
    rd_ok = rd && (m_count != 0);
    wr_ok = wr && ((m_count != DEPTH) || rd);
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.clr_err = clr;
    bus.buf_in  = data;
    popped = '0;
    if (rd_ok) popped = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(data);
    m_count = m_count + int'(wr_ok) - int'(rd_ok);
    if (wr && !wr_ok) m_ovf = 1'b1;
    else if (clr)     m_ovf = 1'b0;
    if (rd && !rd_ok) m_udf = 1'b1;
    else if (clr)     m_udf = 1'b0;
    @(posedge clk);
    #1;
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check_eq("rd_valid", 32'(bus.rd_valid), 32'(rd_ok));
    if (rd_ok) m_last = popped;
    check_eq("buf_out", 32'(bus.buf_out), 32'(m_last));
`endif
    check_state();
  endtask

  task automatic do_reset(input bit wr, input bit rd);
    rst         = 1'b1;
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.clr_err = 1'b0;
    bus.buf_in  = DW'($urandom_range(0, 255));
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_last  = '0;
    check_eq("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check_eq("rst_buf_out", 32'(bus.buf_out), 32'd0);
`endif
    check_state();
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    bus.buf_in  = '0;
    do_reset(1'b0, 1'b0);

    // Ten words in and out in order.
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
    for (int i = 0; i < 10; i++)  step(1'b0, 1'b1, 1'b0, '0);

    // Fill, overflow attempt, clear, drain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom_range(0, 255)));
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Underflow, then read+write at empty, then clear.
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 8'hA0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Full pass-through with wrap-around.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom_range(0, 255)));
    for (int i = 0; i < 5; i++)     step(1'b1, 1'b1, 1'b0, DW'(8'hB0 + i));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, DW'(8'hC0 + i));
    do_reset(1'b1, 1'b1);

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    step(1'b1, 1'b0, 1'b0, 8'h55);
    step(1'b0, 1'b0, 1'b0, '0);
    check_eq("fwft_55_data",  32'(bus.buf_out),  32'h55);
    check_eq("fwft_55_valid", 32'(bus.rd_valid), 32'd1);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("fwft_pop_empty", 32'(bus.buf_empty), 32'd1);
`endif

    // Random mixed traffic including occasional error clears.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), DW'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
